rom_fetch_ctrl: RTL and testbench

ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

---
 rtl/rom_fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_ctrl.sv
// ROM line-fill controller: fetches bytes of one 16-byte cache line from the ROM bus,
// starting at the missing PC and stopping at the end of the line.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no fill in progress, waiting for a cache miss
// WAIT_BUS | fill pending, ROM bus not granted to the GSU
// ACCESS   | rom_rd high, counting ROM access cycles for the byte at fa
// DELIVER  | romrdy strobe, byte at fill_addr written into cache RAM
module rom_fetch_ctrl #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] pc,
    input  logic [7:0]  pbr,
    input  logic        ron,
    input  logic        abort,
    input  logic [7:0]  rom_data,
    output logic [23:0] rom_addr,
    output logic        rom_rd,
    output logic [7:0]  instr_in,
    output logic [15:0] fill_addr,
    output logic        romrdy,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT_BUS, ACCESS, DELIVER} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] fa;
    logic [7:0]  bank;
    logic        romrdy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            fa        <= 16'h0000;
            bank      <= 8'h00;
            instr_in  <= 8'h00;
            fill_addr <= 16'h0000;
            rom_addr  <= 24'h0;
            rom_rd    <= 1'b0;
            romrdy_r  <= 1'b0;
        end else begin
            romrdy_r <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                cnt      <= 4'd0;
                rom_rd   <= 1'b0;
                rom_addr <= 24'h0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fetch_req) begin
                            fa   <= pc;
                            bank <= pbr;
                            cnt  <= 4'd0;
                            if (ron) begin
                                state    <= ACCESS;
                                rom_rd   <= 1'b1;
                                rom_addr <= {pbr, pc};
                            end else begin
                                state <= WAIT_BUS;
                            end
                        end
                    end
                    WAIT_BUS: begin
                        if (ron) begin
                            state    <= ACCESS;
                            cnt      <= 4'd0;
                            rom_rd   <= 1'b1;
                            rom_addr <= {bank, fa};
                        end
                    end
                    ACCESS: begin
                        // Losing the bus throws away the partial access entirely.
                        if (!ron) begin
                            state    <= WAIT_BUS;
                            cnt      <= 4'd0;
                            rom_rd   <= 1'b0;
                            rom_addr <= 24'h0;
                        end else if (cnt == LAST_CNT) begin
                            state     <= DELIVER;
                            cnt       <= 4'd0;
                            instr_in  <= rom_data;
                            fill_addr <= fa;
                            romrdy_r  <= 1'b1;
                            rom_rd    <= 1'b0;
                            rom_addr  <= 24'h0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DELIVER: begin
                        if (fa[3:0] == 4'hF) begin
                            state <= IDLE;
                        end else begin
                            fa  <= fa + 16'd1;
                            cnt <= 4'd0;
                            if (ron) begin
                                state    <= ACCESS;
                                rom_rd   <= 1'b1;
                                rom_addr <= {bank, fa + 16'd1};
                            end else begin
                                state <= WAIT_BUS;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // An abort arriving during DELIVER must keep the cache from writing that byte.
    assign romrdy = romrdy_r & ~abort;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: table of line-fill bursts plus
// hand-written sequences for bus loss, abort, reset and back-to-back requests.
module tb_rom_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] pc;
    logic [7:0]  pbr;
    logic        ron;
    logic        abort;
    logic [7:0]  rom_data;
    logic [23:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  instr_in;
    logic [15:0] fill_addr;
    logic        romrdy;
    logic        busy;

    int checks = 0;
    int failures = 0;

    rom_fetch_ctrl #(.WAIT_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .pbr(pbr),
        .ron(ron), .abort(abort), .rom_data(rom_data), .rom_addr(rom_addr),
        .rom_rd(rom_rd), .instr_in(instr_in), .fill_addr(fill_addr),
        .romrdy(romrdy), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
    endfunction

    assign rom_data = rom_rd ? rom_f(rom_addr) : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rom_addr"},  32'(rom_addr),  32'h0);
        chk({tag, "_rom_rd"},    32'(rom_rd),    32'h0);
        chk({tag, "_romrdy"},    32'(romrdy),    32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_instr_in"},  32'(instr_in),  32'h0);
        chk({tag, "_fill_addr"}, 32'(fill_addr), 32'h0);
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  pbr;
        int          nbytes;
    } burst_t;

    // Cycle 0 = request cycle; byte k (k=0..) strobes romrdy in cycle 4*(k+1).
    task automatic run_burst(input logic [15:0] p, input logic [7:0] b, input int nexp);
        int got;
        logic [15:0] efa;
        step();
        pc = p; pbr = b; ron = 1'b1; fetch_req = 1'b1;
        got = 0;
        for (int c = 1; c <= 80; c++) begin
            step();
            fetch_req = 1'b0; pc = 16'h0000; pbr = 8'h00;
            #1;
            efa = p + 16'(got);
            chk("burst_rd_rdy_exclusive", 32'(rom_rd & romrdy), 32'h0);
            if (rom_rd) begin
                chk("burst_rd_in_burst", 32'(got < nexp), 32'h1);
                chk("burst_rom_addr", 32'(rom_addr), 32'({b, efa}));
            end else begin
                chk("burst_rom_addr_idle", 32'(rom_addr), 32'h0);
            end
            if (romrdy) begin
                chk("burst_fill_addr", 32'(fill_addr), 32'(efa));
                chk("burst_instr_in", 32'(instr_in), 32'(rom_f({b, efa})));
                chk("burst_romrdy_cycle", 32'(c), 32'(4 * (got + 1)));
                got++;
            end
        end
        chk("burst_byte_count", 32'(got), 32'(nexp));
        chk("burst_idle_after", 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        burst_t bursts[5];
        bursts[0] = '{16'h800D, 8'h01, 3};
        bursts[1] = '{16'hFFFF, 8'h7F, 1};
        bursts[2] = '{16'h1230, 8'h22, 16};
        bursts[3] = '{16'hABCF, 8'hFF, 1};
        bursts[4] = '{16'h0008, 8'h00, 8};

        rst_n = 1'b0; fetch_req = 1'b0; pc = 16'h0; pbr = 8'h0; ron = 1'b1; abort = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        chk("post_reset_busy", 32'(busy), 32'h0);

        foreach (bursts[i]) run_burst(bursts[i].pc, bursts[i].pbr, bursts[i].nbytes);

        // Bus not granted at request; ron rises in cycle 5, first byte in cycle 9.
        step();
        pc = 16'h4A2F; pbr = 8'h3C; ron = 1'b0; fetch_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            fetch_req = 1'b0; pc = 16'h0;
            ron = (c >= 5);
            #1;
            if (c <= 5) begin
                chk("ron_wait_rd_low", 32'(rom_rd), 32'h0);
                chk("ron_wait_busy", 32'(busy), 32'h1);
            end
            if (c >= 6 && c <= 8) chk("ron_wait_rd_high", 32'(rom_rd), 32'h1);
            chk("ron_wait_romrdy", 32'(romrdy), 32'(c == 9));
            if (c == 9) begin
                chk("ron_wait_fill_addr", 32'(fill_addr), 32'h4A2F);
                chk("ron_wait_instr", 32'(instr_in), 32'(rom_f(24'h3C4A2F)));
            end
        end
        chk("ron_wait_idle", 32'(busy), 32'h0);

        // Bus lost during the 2nd access cycle, regained in cycle 4: full restart.
        step();
        pc = 16'h1230; pbr = 8'h05; ron = 1'b1; fetch_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            fetch_req = 1'b0; pc = 16'h0;
            ron = !(c == 2 || c == 3);
            #1;
            chk("ron_drop_rd", 32'(rom_rd), 32'(c == 1 || c == 2 || (c >= 5 && c <= 7)));
            if (!rom_rd) chk("ron_drop_addr_zero", 32'(rom_addr), 32'h0);
            if (c >= 5 && c <= 7) chk("ron_drop_addr", 32'(rom_addr), 32'h051230);
            chk("ron_drop_romrdy", 32'(romrdy), 32'(c == 8));
            if (c == 8) begin
                chk("ron_drop_fill_addr", 32'(fill_addr), 32'h1230);
                chk("ron_drop_instr", 32'(instr_in), 32'(rom_f(24'h051230)));
            end
        end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("ron_drop_abort_idle", 32'(busy), 32'h0);
        chk("ron_drop_abort_rd", 32'(rom_rd), 32'h0);

        // Abort during DELIVER of byte 2 of a burst from 8000.
        step();
        pc = 16'h8000; pbr = 8'h44; ron = 1'b1; fetch_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            fetch_req = 1'b0;
            abort = (c == 8);
            #1;
            chk("abort_romrdy", 32'(romrdy), 32'(c == 4));
            if (c == 4) chk("abort_byte1_addr", 32'(fill_addr), 32'h8000);
            if (c == 8) chk("abort_deliver_busy", 32'(busy), 32'h1);
        end
        step();
        abort = 1'b0;
        #1;
        chk("abort_idle_next", 32'(busy), 32'h0);
        for (int c = 0; c < 10; c++) begin
            step();
            #1;
            chk("abort_no_rd", 32'(rom_rd | romrdy), 32'h0);
        end

        // Reset pulse mid-ACCESS abandons the burst.
        step();
        pc = 16'h5555; pbr = 8'h11; ron = 1'b1; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        chk("rst_mid_rd_before", 32'(rom_rd), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            #1;
            chk("rst_mid_quiet", 32'({busy, rom_rd, romrdy}), 32'h0);
        end

        // fetch_req held high: ignored while busy, restarts from current pc after the burst.
        step();
        pc = 16'h200F; pbr = 8'h09; ron = 1'b1; fetch_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            pc = 16'h300F;
            fetch_req = (c <= 5);
            #1;
            chk("held_romrdy", 32'(romrdy), 32'(c == 4 || c == 9));
            if (c <= 3) chk("held_addr_first", 32'(rom_addr), 32'h09200F);
            if (c >= 6 && c <= 8) chk("held_addr_second", 32'(rom_addr), 32'h09300F);
            if (c == 4) chk("held_fill_first", 32'(fill_addr), 32'h200F);
            if (c == 9) begin
                chk("held_fill_second", 32'(fill_addr), 32'h300F);
                chk("held_instr_second", 32'(instr_in), 32'(rom_f(24'h09300F)));
            end
        end
        chk("held_idle_end", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
